// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: state encoding, header
// field positions and the widths of the computer's test/load port.
package prog_loader_pkg;

  localparam int ADDR_W       = 8;
  localparam int DATA_W       = 16;
  localparam int HDR_ADDR_MSB = 15;
  localparam int HDR_ADDR_LSB = 8;
  localparam int HDR_CNT_MSB  = 7;
  localparam int HDR_CNT_LSB  = 0;
  localparam int CNT_W        = HDR_CNT_MSB - HDR_CNT_LSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CRST,
    ST_RUN,
    ST_RESULT
  } state_e;

endpackage

// File: rtl/prog_loader_run_timer.sv
// Run-cycle counter: clears while the CPU is not running, counts enabled
// cycles, and flags the terminal count TIMEOUT-1 (TIMEOUT must be < 2**CW).
module prog_loader_run_timer #(
  parameter int TIMEOUT = 4096,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          tc
);

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/prog_loader.sv
// Host-side loader: takes a header plus N data words, writes them into CPU
// memory, pulses cpu_reset, runs the CPU until done or timeout, holds result.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int TIMEOUT = 4096,
  parameter int CW      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addr_tb,
  output logic [DATA_W-1:0] data_tb,
  output logic              we_tb,
  output logic              cpu_reset,
  output logic              cpu_on,
  input  logic              done,
  input  logic [DATA_W-1:0] out_r,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ack,
  output logic [DATA_W-1:0] result,
  output logic              timeout,
  output logic [CW-1:0]     cycles
);

  state_e             state;
  state_e             state_nxt;
  logic [ADDR_W-1:0]  ptr;
  logic [CNT_W-1:0]   remaining;
  logic               accept;
  logic               run_end;
  logic               tc;

  assign accept  = in_valid && in_ready;
  assign run_end = (state == ST_RUN) && (done || tc);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (in_data[HDR_CNT_MSB:HDR_CNT_LSB] == '0) ? ST_CRST : ST_LOAD;
        end
      end
      ST_LOAD:   if (accept && remaining == CNT_W'(1)) state_nxt = ST_CRST;
      ST_CRST:   state_nxt = ST_RUN;
      ST_RUN:    if (done || tc) state_nxt = ST_RESULT;
      ST_RESULT: if (res_ack && res_valid) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and CPU control are decoded from the state register only.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    cpu_on    = 1'b0;
    cpu_reset = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_LOAD: in_ready  = 1'b1;
      ST_CRST: cpu_reset = 1'b1;
      ST_RUN:  cpu_on    = 1'b1;
      default: ;
    endcase
  end

  // NOTE: reset clears every datapath register so an abort mid-load drops
  // the pending write and leaves no stale result behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      remaining <= '0;
      we_tb     <= 1'b0;
      addr_tb   <= '0;
      data_tb   <= '0;
      res_valid <= 1'b0;
      result    <= '0;
      timeout   <= 1'b0;
    end else begin
      we_tb <= 1'b0;
      if (state == ST_IDLE && accept) begin
        ptr       <= in_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
        remaining <= in_data[HDR_CNT_MSB:HDR_CNT_LSB];
      end
      // Pointer wraps naturally at 256, matching the CPU's 8-bit address space.
      if (state == ST_LOAD && accept) begin
        we_tb     <= 1'b1;
        addr_tb   <= ptr;
        data_tb   <= in_data;
        ptr       <= ptr + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
      if (run_end) begin
        res_valid <= 1'b1;
        timeout   <= !done;
        result    <= done ? out_r : '0;
      end
      if (state == ST_RESULT && res_ack && res_valid) begin
        res_valid <= 1'b0;
      end
    end
  end

  // The count freezes on the done/abort cycle and is held through RESULT.
  prog_loader_run_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_run_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!(state == ST_RUN || state == ST_RESULT)),
    .enable (state == ST_RUN && !done && !tc),
    .count  (cycles),
    .tc     (tc)
  );

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side initiator for the computer's test/load port (addr_tb, data_tb, we_tb, cpu_on, done, out_r).
- Accepts a 16-bit word stream, writes the program image into CPU memory, then resets and starts the CPU.
- Waits for done, bounded by a timeout, then captures out_r and presents it with a run-cycle count.
- Sits between a host link (UART/bench stream) and the computer top, replacing bench-driven loading.

Parameters:
- TIMEOUT, 4096: maximum run cycles with cpu_on=1 before the run is aborted.
- CW, 16: width of the run-cycle counter; TIMEOUT must be less than 2^CW.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  stream word valid.
- in_data  in  16  stream word.
- in_ready  out  1  loader accepts in_data this cycle.
- addr_tb  out  8  memory write address to computer.
- data_tb  out  16  memory write data to computer.
- we_tb  out  1  memory write strobe to computer.
- cpu_reset  out  1  reset pulse to computer (PC/control).
- cpu_on  out  1  CPU run enable.
- done  in  1  CPU finished (from computer).
- out_r  in  16  CPU result (from computer).
- busy  out  1  loader not in IDLE.
- res_valid  out  1  result/status held valid.
- res_ack  in  1  host consumed result.
- result  out  16  captured out_r.
- timeout  out  1  run aborted by TIMEOUT; qualified by res_valid.
- cycles  out  CW  cpu_on cycles counted until done or abort.

Behaviour:
- Reset (sync, active-high, one clk edge): state=IDLE. All outputs 0 except in_ready=1 (IDLE). Applies mid-load or mid-run: cpu_on drops the next cycle, pending write is dropped, and the counters clear.
- Stream handshake: a word transfers on a clk edge with in_valid&in_ready. in_ready=1 only in IDLE and LOAD.
- IDLE: the accepted word is the header. Bits [15:8] are base address A; bits [7:0] are word count N.
  - N!=0: latch A into the address pointer, remaining=N, go to LOAD.
  - N==0: skip loading and go to CRST; this re-runs the program already in memory.
- LOAD: each accepted word is registered.
  - The next cycle drives we_tb=1 for exactly one cycle, with addr_tb=pointer and data_tb=word. Write latency is 1 cycle after the handshake.
  - Pointer increments mod 256, so A+N>256 wraps to address 0.
  - On the handshake of the last word (remaining==1), in_ready goes 0 next cycle and the state goes to CRST. The final we_tb pulse coincides with the first CRST cycle.
  - Back-to-back words give one write per cycle. Idle in_valid gaps insert no writes.
  - cpu_on=0 throughout LOAD.
- CRST: cpu_reset=1 for exactly one cycle; cpu_on=0. Then go to RUN.
- RUN: cpu_on=1 and cycles increments each cycle, starting from 0.
  - done=1 sampled: capture result<=out_r and timeout<=0, set res_valid=1, cpu_on=0 next cycle, go to RESULT. cycles holds its value excluding the done cycle.
  - cycles==TIMEOUT-1 and done=0: set res_valid=1, timeout=1, result=0, cpu_on=0, go to RESULT.
  - done and timeout in the same cycle: done wins.
  - done is ignored outside RUN.
- RESULT: res_valid, result, timeout and cycles are held stable; in_ready=0.
  - res_ack=1 clears res_valid and returns to IDLE the next cycle.
  - res_ack is ignored when res_valid=0.
- Outputs are registered; there is no combinational path from inputs to outputs except in_ready, which is state-decoded only.
- busy=1 in LOAD, CRST, RUN and RESULT.

Decomposition:
- Shared package:
  - loader state enum (IDLE, LOAD, CRST, RUN, RESULT);
  - header field positions (HDR_ADDR_MSB=15, HDR_ADDR_LSB=8, HDR_CNT_MSB=7);
  - ADDR_W=8 and DATA_W=16, matching the computer's tb port.
- Sub-module: run_timer, the CW-bit cycle counter with clear/enable and a terminal-count flag against TIMEOUT. The rest is flat.

Test Plan:
- Basic load+run: header 0x1003, then words 0xAAAA, 0x5555, 0x1234 back-to-back.
  - Required: we_tb pulses at addr 0x10, 0x11, 0x12 with those data on consecutive cycles.
  - Required: a single cpu_reset pulse, then cpu_on=1.
  - Stimulus: done asserted with out_r=0x00FF after 20 run cycles. Required: result=0x00FF, timeout=0, cycles=20, res_valid=1.
- Gapped stream + wrap: header 0xFE03, with in_valid low 2 cycles between words.
  - Required: writes at 0xFE, 0xFF, 0x00, in order, one pulse per word, and none during gaps.
- Zero count: header 0x4000.
  - Required: no we_tb; cpu_reset on the next cycle, then cpu_on.
- Timeout: TIMEOUT=16 and done held 0.
  - Required: cpu_on high exactly 16 cycles, then res_valid=1, timeout=1, result=0x0000, cycles=15.
  - Required: res_ack returns to IDLE with in_ready=1.
- Reset mid-operation: assert reset during LOAD after 1 of 3 words, and again during RUN.
  - Required: the next cycle has cpu_on=0, we_tb=0, res_valid=0, busy=0 and in_ready=1.
  - Required: the next header is treated as a header.
- Done/timeout collision: done=1 on cycle TIMEOUT-1.
  - Required: timeout=0 and result=out_r.
  - Required: res_ack held high before res_valid has no effect.
